// File: rtl/card_pkg.sv
// Shared types and constants for the card shoe.
package card_pkg;
  typedef logic [3:0] rank_t;

  localparam rank_t RANK_NONE = 4'd0;
  localparam rank_t RANK_ACE  = 4'd1;
  localparam rank_t RANK_KING = 4'd13;
  localparam int    CARDS_PER_RANK = 4;

  typedef enum logic [1:0] {IDLE, SEARCH, REFILL} shoe_state_t;

  function automatic rank_t next_rank(input rank_t r);
    return (r == RANK_KING) ? RANK_ACE : rank_t'(r + 4'd1);
  endfunction
endpackage

// File: rtl/rank_counter.sv
// Wrap-around 1..13 rank counter with synchronous load and advance enable.
module rank_counter
  import card_pkg::*;
(
  input  logic  clock,
  input  logic  load_i,
  input  rank_t load_val_i,
  input  logic  en_i,
  output rank_t q_o
);
  rank_t q_q;

  always_ff @(posedge clock) begin
    if (load_i)    q_q <= load_val_i;
    else if (en_i) q_q <= next_rank(q_q);
  end

  assign q_o = q_q;
endmodule

// File: rtl/card_shoe.sv
// Finite-deck card source: deals ranks without replacement, refills when empty or on request.
module card_shoe
  import card_pkg::*;
#(
  parameter  int NUM_DECKS = 1,
  localparam int LW = $clog2(52*NUM_DECKS+1),
  localparam int CW = $clog2(CARDS_PER_RANK*NUM_DECKS+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          deal_req,
  input  logic          shuffle,
  output rank_t         card,
  output logic          card_valid,
  output logic          busy,
  output logic [LW-1:0] cards_left,
  output logic          reshuffled
);
  localparam logic [CW-1:0] FULL_RANK = CW'(CARDS_PER_RANK*NUM_DECKS);
  localparam logic [LW-1:0] FULL_SHOE = LW'(52*NUM_DECKS);

  shoe_state_t            state_q, state_d;
  logic                   pend_q, pend_d;
  rank_t                  card_q, card_d;
  logic                   valid_q, valid_d;
  logic                   resh_q, resh_d;
  logic [LW-1:0]          left_q, left_d;
  logic [13:1][CW-1:0]    cnt_q, cnt_d;

  rank_t         rng_q, ptr_q, ptr_ld_val, exam_rank;
  logic          ptr_load, ptr_en, take, do_refill, hit;
  logic [CW-1:0] exam_cnt;

  rank_counter u_rng (
    .clock      (clock),
    .load_i     (reset),
    .load_val_i (RANK_ACE),
    .en_i       (1'b1),
    .q_o        (rng_q)
  );

  // An empty shoe deals rng itself after refill; a miss in IDLE resumes at the next rank.
  assign ptr_ld_val = (left_q == '0) ? rng_q : next_rank(rng_q);

  rank_counter u_ptr (
    .clock      (clock),
    .load_i     (reset | ptr_load),
    .load_val_i (reset ? RANK_ACE : ptr_ld_val),
    .en_i       (ptr_en),
    .q_o        (ptr_q)
  );

  // IDLE examines the live rng so an available rank is dealt with single-cycle latency.
  assign exam_rank = (state_q == IDLE) ? rng_q : ptr_q;

  always_comb begin
    exam_cnt = '0;
    for (int r = 1; r <= 13; r++)
      if (exam_rank == rank_t'(r)) exam_cnt = cnt_q[r];
  end

  assign hit = (exam_cnt != '0);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    card_d    = card_q;
    valid_d   = 1'b0;
    resh_d    = 1'b0;
    left_d    = left_q;
    cnt_d     = cnt_q;
    ptr_load  = 1'b0;
    ptr_en    = 1'b0;
    take      = 1'b0;
    do_refill = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (shuffle) begin
          state_d   = REFILL;
          do_refill = 1'b1;
        end else if (deal_req) begin
          if (left_q == '0) begin
            state_d   = REFILL;
            pend_d    = 1'b1;
            ptr_load  = 1'b1;
            do_refill = 1'b1;
          end else if (hit) begin
            take = 1'b1;
          end else begin
            state_d  = SEARCH;
            ptr_load = 1'b1;
          end
        end
      end
      SEARCH: begin
        if (shuffle) begin
          state_d   = REFILL;
          pend_d    = 1'b0;
          do_refill = 1'b1;
        end else if (hit) begin
          take = 1'b1;
        end else begin
          ptr_en = 1'b1;
        end
      end
      REFILL: begin
        state_d = IDLE;
        pend_d  = 1'b0;
        take    = pend_q;
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d = IDLE;
      card_d  = exam_rank;
      valid_d = 1'b1;
      left_d  = left_q - LW'(1);
      for (int r = 1; r <= 13; r++)
        if (exam_rank == rank_t'(r)) cnt_d[r] = cnt_q[r] - CW'(1);
    end

    // Counts are refilled on entry so REFILL can deal a pending request directly.
    if (do_refill) begin
      resh_d = 1'b1;
      left_d = FULL_SHOE;
      for (int r = 1; r <= 13; r++) cnt_d[r] = FULL_RANK;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      card_q  <= RANK_NONE;
      valid_q <= 1'b0;
      resh_q  <= 1'b0;
      left_q  <= FULL_SHOE;
      for (int r = 1; r <= 13; r++) cnt_q[r] <= FULL_RANK;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      card_q  <= card_d;
      valid_q <= valid_d;
      resh_q  <= resh_d;
      left_q  <= left_d;
      cnt_q   <= cnt_d;
    end
  end

  assign card       = card_q;
  assign card_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign cards_left = left_q;
  assign reshuffled = resh_q;
endmodule

// File: tb/tb_card_shoe.sv
// Randomized directed bench for card_shoe against a rank-count reference model.
module tb_card_shoe;
  localparam int ND = 1;
  localparam int LW = $clog2(52*ND+1);

  logic          clock = 1'b0;
  logic          reset, deal_req, shuffle;
  logic [3:0]    card;
  logic          card_valid, busy, reshuffled;
  logic [LW-1:0] cards_left;

  card_shoe #(.NUM_DECKS(ND)) dut (
    .clock(clock), .reset(reset), .deal_req(deal_req), .shuffle(shuffle),
    .card(card), .card_valid(card_valid), .busy(busy),
    .cards_left(cards_left), .reshuffled(reshuffled)
  );

  always #5 clock = ~clock;

  // Reference rng: 1 while reset is sampled, then 1..13 wrapping every clock.
  int m_rng = 1;
  always @(posedge clock) m_rng <= reset ? 1 : (m_rng % 13) + 1;

  int m_cnt [1:13];
  int m_left, m_card;
  int hist  [1:13];
  int npass = 0, nfail = 0, ntot = 0;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_refill();
    for (int r = 1; r <= 13; r++) m_cnt[r] = 4*ND;
    m_left = 52*ND;
  endtask

  // want: rank rng must show when requesting (0 = any); extra: re-request while busy.
  task automatic do_deal(input int want, input bit extra);
    int r, k, lat;
    bit refill;
    if (want != 0) begin
      for (int i = 0; i < 14 && m_rng != want; i++) tick();
      if (m_rng != want) chk("rng_wait", m_rng, want);
    end
    r = m_rng;
    refill = (m_left == 0);
    if (refill) model_refill();
    k = 0;
    while (m_cnt[r] == 0) begin
      r = (r % 13) + 1;
      k++;
    end
    lat = 1 + k + (refill ? 1 : 0);
    m_cnt[r]--;
    m_left--;
    m_card = r;
    hist[r]++;
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      if (c < lat) begin
        chk("early_valid", card_valid, 0);
        chk("busy_search", busy, 1);
        if (refill && c == 1) chk("refill_pulse", reshuffled, 1);
        if (extra && c == 1) deal_req = 1'b1;
        tick();
        deal_req = 1'b0;
      end else begin
        chk("valid", card_valid, 1);
        chk("card", card, m_card);
        chk("busy_done", busy, 0);
        chk("left", cards_left, m_left);
      end
    end
    if (extra) begin
      tick();
      chk("ignored_req_valid", card_valid, 0);
      chk("ignored_req_busy", busy, 0);
    end
  endtask

  task automatic do_shuffle(input bit with_deal);
    shuffle  = 1'b1;
    deal_req = with_deal;
    tick();
    shuffle  = 1'b0;
    deal_req = 1'b0;
    model_refill();
    chk("shuf_pulse", reshuffled, 1);
    chk("shuf_valid", card_valid, 0);
    chk("shuf_left", cards_left, m_left);
    chk("shuf_card", card, m_card);
    tick();
    chk("shuf_idle", busy, 0);
    chk("shuf_novalid", card_valid, 0);
  endtask

  initial begin
    reset = 1'b1; deal_req = 1'b0; shuffle = 1'b0;
    model_refill();
    m_card = 0;
    for (int r = 1; r <= 13; r++) hist[r] = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_card", card, 0);
    chk("rst_valid", card_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_left", cards_left, 52*ND);
    chk("rst_resh", reshuffled, 0);

    // Drain rank 5, then one more request at 5 must skip to 6; a king deals directly.
    for (int i = 0; i < 4*ND + 1; i++) do_deal(5, 1'b0);
    chk("skip_card", card, 6);
    do_deal(13, 1'b0);

    // Fresh shoe, full drain at random phases, then an empty-shoe request.
    do_shuffle(1'b0);
    for (int r = 1; r <= 13; r++) hist[r] = 0;
    for (int i = 0; i < 52*ND; i++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      do_deal(0, 1'b0);
    end
    for (int r = 1; r <= 13; r++) chk("hist", hist[r], 4*ND);
    chk("drained", cards_left, 0);
    do_deal(0, 1'b0);
    chk("after_refill_left", cards_left, 52*ND - 1);

    // Exhaust rank 7, start a search from 7, abort it with shuffle.
    while (m_cnt[7] > 0) do_deal(7, 1'b0);
    for (int i = 0; i < 14 && m_rng != 7; i++) tick();
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    chk("abort_busy", busy, 1);
    chk("abort_early", card_valid, 0);
    do_shuffle(1'b0);

    // Simultaneous deal and shuffle refill only.
    do_shuffle(1'b1);

    // A request while searching is dropped.
    while (m_cnt[3] > 0) do_deal(3, 1'b0);
    do_deal(3, 1'b1);

    // Reset during a search.
    for (int i = 0; i < 14 && m_rng != 3; i++) tick();
    deal_req = 1'b1;
    tick();
    deal_req = 1'b0;
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_refill();
    m_card = 0;
    chk("midrst_valid", card_valid, 0);
    chk("midrst_card", card, 0);
    chk("midrst_left", cards_left, 52*ND);
    chk("midrst_busy", busy, 0);
    chk("midrst_resh", reshuffled, 0);
    do_deal(0, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
